// File: rtl/matmul_sequencer.sv
// Protocol sequencer for the 3x3 UART matrix multiplier: parses the host
// command stream, loads matrix memories, kicks the Calculator and streams back the result.
module matmul_sequencer #(
  parameter logic [7:0] START_BYTE   = 8'hA5,
  parameter logic [7:0] MAT_SIZE     = 8'd3,
  parameter int unsigned N_ELEM       = 9,
  parameter int unsigned RES_W        = 16,
  parameter int unsigned MULT_TIMEOUT = 255,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  input  logic                      tx_busy,
  input  logic                      mult_done,
  input  logic [N_ELEM*RES_W-1:0]   result,
  output logic                      wr_en_a,
  output logic                      wr_en_b,
  output logic [3:0]                wr_addr,
  output logic [7:0]                wr_data,
  output logic                      mult_start,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  output logic [2:0]                current_state,
  output logic                      error
);

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    RECEIVE_SIZE     = 3'd1,
    RECEIVE_MATRIX_A = 3'd2,
    RECEIVE_MATRIX_B = 3'd3,
    COMPUTE          = 3'd4,
    SEND_RESULT      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TX_READY   = 2'd0,
    TX_WAIT_HI = 2'd1,
    TX_WAIT_LO = 2'd2
  } phase_t;

  localparam logic [3:0] LAST_ELEM = 4'(N_ELEM - 1);
  localparam logic [4:0] LAST_BYTE = 5'(2 * N_ELEM - 1);
  localparam logic [7:0] MULT_TO   = 8'(MULT_TIMEOUT);
  localparam logic [7:0] BUSY_TO   = 8'(BUSY_TIMEOUT);

  state_t                    state, state_n;
  phase_t                    phase, phase_n;
  logic [3:0]                cnt, cnt_n;
  logic [4:0]                byte_idx, byte_n;
  logic [7:0]                timer, timer_n;
  logic                      err_n;
  logic                      capture;
  logic [N_ELEM*RES_W-1:0]   res_q;
  logic [7:0]                tx_data_q;
  logic [7:0]                byte_pos;
  logic [7:0]                cur_byte;

  // Byte b lives at bit offset 8*(b^1): even b is the high byte of element b/2.
  assign byte_pos = {byte_idx ^ 5'd1, 3'b000};
  assign cur_byte = res_q[byte_pos +: 8];

  assign current_state = state;
  assign tx_data       = tx_start ? cur_byte : tx_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= TX_READY;
      cnt       <= '0;
      byte_idx  <= '0;
      timer     <= '0;
      error     <= 1'b0;
      res_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      byte_idx <= byte_n;
      timer    <= timer_n;
      error    <= err_n;
      if (capture) res_q <= result;
      if (tx_start) tx_data_q <= cur_byte;
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    byte_n     = byte_idx;
    timer_n    = timer;
    err_n      = error;
    capture    = 1'b0;
    wr_en_a    = 1'b0;
    wr_en_b    = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    mult_start = 1'b0;
    tx_start   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && rx_data == START_BYTE) begin
          state_n = RECEIVE_SIZE;
          err_n   = 1'b0;
        end
      end
      RECEIVE_SIZE: begin
        if (rx_valid) begin
          if (rx_data == MAT_SIZE) begin
            state_n = RECEIVE_MATRIX_A;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
      end
      RECEIVE_MATRIX_A, RECEIVE_MATRIX_B: begin
        if (rx_valid) begin
          wr_en_a = (state == RECEIVE_MATRIX_A);
          wr_en_b = (state == RECEIVE_MATRIX_B);
          wr_addr = cnt;
          wr_data = rx_data;
          if (cnt == LAST_ELEM) begin
            cnt_n   = '0;
            timer_n = '0;
            state_n = (state == RECEIVE_MATRIX_A) ? RECEIVE_MATRIX_B : COMPUTE;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      COMPUTE: begin
        // timer == 0 only in the entry cycle; a done seen then is stale.
        mult_start = (timer == 8'd0);
        timer_n    = timer + 8'd1;
        if (mult_done && !mult_start) begin
          capture = 1'b1;
          state_n = SEND_RESULT;
          phase_n = TX_READY;
          byte_n  = '0;
          timer_n = '0;
        end else if (timer_n == MULT_TO) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      SEND_RESULT: begin
        case (phase)
          TX_READY: begin
            if (!tx_busy) begin
              tx_start = 1'b1;
              phase_n  = TX_WAIT_HI;
              timer_n  = '0;
            end
          end
          TX_WAIT_HI: begin
            if (tx_busy) begin
              phase_n = TX_WAIT_LO;
            end else begin
              timer_n = timer + 8'd1;
              if (timer_n == BUSY_TO) begin
                err_n   = 1'b1;
                state_n = IDLE;
                phase_n = TX_READY;
              end
            end
          end
          TX_WAIT_LO: begin
            if (!tx_busy) begin
              phase_n = TX_READY;
              if (byte_idx == LAST_BYTE) state_n = IDLE;
              else byte_n = byte_idx + 5'd1;
            end
          end
          default: phase_n = TX_READY;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: expected writes and tx bytes are queued
// as stimulus is driven and popped as the DUT produces them.
module tb_matmul_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         tx_busy;
  logic         mult_done = 1'b0;
  logic [143:0] result = '0;
  logic         wr_en_a, wr_en_b, mult_start, tx_start, error;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data, tx_data;
  logic [2:0]   current_state;

  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  logic mult_en    = 1'b1;
  assign tx_busy = model_busy | hold_busy;

  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  int mult_count = 0;

  logic [12:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  mat_a[9];
  logic [7:0]  mat_b[9];
  logic [7:0]  exp_last;

  always #5 clk = ~clk;

  matmul_sequencer #(
    .START_BYTE(8'hA5),
    .MAT_SIZE(8'd3),
    .N_ELEM(9),
    .RES_W(16),
    .MULT_TIMEOUT(255),
    .BUSY_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .mult_done(mult_done), .result(result),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .mult_start(mult_start), .tx_start(tx_start), .tx_data(tx_data),
    .current_state(current_state), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor
  initial forever begin
    @(negedge clk);
    if (wr_en_a || wr_en_b || mult_start || tx_start)
      check("onehot", 32'($countones({wr_en_a, wr_en_b, mult_start, tx_start})), 1);
    if (wr_en_a || wr_en_b) begin
      if (exp_wr.size() == 0) check("wr_unexpected", {wr_en_b, wr_addr, wr_data}, 32'h1FFF);
      else check("wr", {19'd0, wr_en_b, wr_addr, wr_data}, {19'd0, exp_wr.pop_front()});
    end
    if (mult_start) mult_count++;
    if (tx_start) begin
      tx_count++;
      check("tx_while_busy", tx_busy, 0);
      if (exp_tx.size() == 0) check("tx_unexpected", tx_data, 32'h100);
      else check("tx_byte", tx_data, exp_tx.pop_front());
    end
  end

  // uart_tx model: busy rises 2 cycles after tx_start, stays 10 cycles
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      repeat (2) @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (10) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  // Calculator model: done pulse 5 cycles after start
  initial forever begin
    @(negedge clk);
    if (mult_start && mult_en) begin
      repeat (5) @(posedge clk);
      #1 mult_done = 1'b1;
      @(posedge clk);
      #1 mult_done = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while (current_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, current_state, s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Computes A*B, loads the Calculator model and queues expected tx bytes.
  task automatic prepare_result(input bit expect_tx);
    logic [15:0] c;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        c = '0;
        for (int k = 0; k < 3; k++) c = c + 16'(mat_a[i*3+k]) * 16'(mat_b[k*3+j]);
        result[16*(i*3+j) +: 16] = c;
        if (expect_tx) begin
          exp_tx.push_back(c[15:8]);
          exp_tx.push_back(c[7:0]);
        end
        exp_last = c[7:0];
      end
  endtask

  task automatic send_header();
    send_byte(8'hA5);
    send_byte(8'h03);
  endtask

  task automatic send_matrices();
    for (int i = 0; i < 9; i++) begin
      exp_wr.push_back({1'b0, 4'(i), mat_a[i]});
      send_byte(mat_a[i]);
    end
    for (int i = 0; i < 9; i++) begin
      exp_wr.push_back({1'b1, 4'(i), mat_b[i]});
      send_byte(mat_b[i]);
    end
  endtask

  task automatic finish_txn(input string tag, input int m0);
    wait_state(3'd5, 100, {tag, "_to_send"});
    wait_state(3'd0, 1000, {tag, "_to_idle"});
    check({tag, "_tx_left"}, exp_tx.size(), 0);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
    check({tag, "_mult_pulses"}, mult_count - m0, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_tx_hold"}, tx_data, exp_last);
  endtask

  initial begin
    int m0, t0, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", current_state, 0);
    check("rst_outputs", {wr_en_a, wr_en_b, wr_addr, wr_data, mult_start, tx_start, tx_data, error}, 0);

    // Full transaction: A = 1..9, B = identity
    for (int i = 0; i < 9; i++) begin
      mat_a[i] = 8'(i + 1);
      mat_b[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
    end
    m0 = mult_count;
    prepare_result(1'b1);
    send_header();
    send_matrices();
    finish_txn("ident", m0);

    // All-2 matrices: every element 16'h000C
    for (int i = 0; i < 9; i++) begin
      mat_a[i] = 8'd2;
      mat_b[i] = 8'd2;
    end
    m0 = mult_count;
    prepare_result(1'b1);
    send_header();
    send_matrices();
    finish_txn("twos", m0);

    // Bad size byte
    send_byte(8'hA5);
    send_byte(8'h04);
    @(negedge clk);
    check("badsize_error", error, 1);
    check("badsize_state", current_state, 0);
    send_byte(8'hA5);
    @(negedge clk);
    check("start_clears_error", error, 0);
    check("start_state", current_state, 1);
    do_reset();

    // Multiplier timeout
    mult_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mat_a[i] = 8'(3 * i + 7);
      mat_b[i] = 8'(i ^ 5);
    end
    t0 = tx_count;
    m0 = mult_count;
    send_header();
    send_matrices();
    wait_state(3'd4, 10, "to_compute");
    n = 0;
    while (current_state == 3'd4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 255);
    check("timeout_error", error, 1);
    check("timeout_state", current_state, 0);
    check("timeout_no_tx", tx_count - t0, 0);
    check("timeout_mult_pulses", mult_count - m0, 1);
    mult_en = 1'b1;

    // Reset mid-stream after 4th A byte
    send_header();
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back({1'b0, 4'(i), 8'(i + 8'h40)});
      send_byte(8'(i + 8'h40));
    end
    do_reset();
    @(negedge clk);
    check("midrst_state", current_state, 0);
    check("midrst_outputs", {wr_en_a, wr_en_b, wr_addr, wr_data, mult_start, tx_start, tx_data, error}, 0);
    for (int i = 0; i < 9; i++) begin
      mat_a[i] = 8'($urandom_range(0, 255));
      mat_b[i] = 8'($urandom_range(0, 255));
    end
    m0 = mult_count;
    prepare_result(1'b1);
    send_header();
    send_matrices();
    finish_txn("after_rst", m0);

    // Back-pressure and stray bytes during SEND_RESULT
    for (int i = 0; i < 9; i++) begin
      mat_a[i] = 8'(9 - i);
      mat_b[i] = 8'(2 * i + 1);
    end
    m0 = mult_count;
    hold_busy = 1'b1;
    prepare_result(1'b1);
    send_header();
    send_matrices();
    wait_state(3'd5, 100, "bp_to_send");
    t0 = tx_count;
    repeat (100) @(posedge clk);
    check("bp_no_tx_while_busy", tx_count - t0, 0);
    #1 hold_busy = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    @(negedge clk);
    check("stray_state", current_state, 5);
    wait_state(3'd0, 1000, "bp_to_idle");
    check("bp_tx_left", exp_tx.size(), 0);
    check("bp_wr_left", exp_wr.size(), 0);
    check("bp_mult_pulses", mult_count - m0, 1);
    check("bp_error", error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Top-level protocol sequencer for the 3x3 UART matrix multiplier.
- Sits between uart_rx/uart_tx, the two matrix memories and the Calculator, all on the baud-derived clock.
- Parses the host command stream (start byte, size byte, 9 bytes of A, 9 bytes of B) and writes each byte into the A or B memory.
- Then pulses the multiplier, captures the 144-bit result and streams it back as 18 bytes through the uart_tx start/busy handshake.

Parameters:
- START_BYTE, 8'hA5, command byte that opens a transaction.
- MAT_SIZE, 3, only accepted size byte value.
- N_ELEM, 9, elements per matrix.
- RES_W, 16, bits per result element.
- MULT_TIMEOUT, 255, max cycles waiting for mult_done.
- BUSY_TIMEOUT, 8, max cycles waiting for tx_busy to rise after tx_start.

Ports:
- clk, input, 1, system clock (bclk at top level).
- rst, input, 1, synchronous active-high reset.
- rx_valid, input, 1, one-cycle strobe; rx_data valid.
- rx_data, input, 8, received byte.
- tx_busy, input, 1, uart_tx busy.
- mult_done, input, 1, Calculator result valid (level or pulse).
- result, input, N_ELEM*RES_W (144), R00..R22; element k at [16k+15:16k].
- wr_en_a, output, 1, write strobe, memory A.
- wr_en_b, output, 1, write strobe, memory B.
- wr_addr, output, 4, element address 0..8.
- wr_data, output, 8, byte to write.
- mult_start, output, 1, one-cycle multiply start.
- tx_start, output, 1, one-cycle transmit request.
- tx_data, output, 8, byte to transmit.
- current_state, output, 3, FSM state.
- error, output, 1, sticky fault flag.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset, including mid-operation:
  - state = IDLE; element/byte counters = 0; captured result = 0.
  - All outputs 0.
  - Aborts any transaction; the next transaction begins at START_BYTE.
- State encodings:
  - IDLE = 0, RECEIVE_SIZE = 1, RECEIVE_MATRIX_A = 2, RECEIVE_MATRIX_B = 3, COMPUTE = 4, SEND_RESULT = 5.
  - 6 and 7 are unreachable; if entered, go to IDLE next cycle.
- IDLE:
  - rx_valid with rx_data == START_BYTE: go to RECEIVE_SIZE and clear error.
  - Any other byte: ignored.
- RECEIVE_SIZE, on rx_valid:
  - rx_data == MAT_SIZE: go to RECEIVE_MATRIX_A with cnt = 0.
  - Otherwise: set error, go to IDLE.
- RECEIVE_MATRIX_A / RECEIVE_MATRIX_B, on rx_valid:
  - Same-cycle combinational outputs: wr_en_a (or wr_en_b) = 1, wr_addr = cnt, wr_data = rx_data.
  - cnt increments.
  - The write of cnt == 8 moves A to B (cnt = 0), or moves B to COMPUTE.
  - No write strobe without rx_valid.
- COMPUTE:
  - mult_start is high exactly in the first cycle after entry.
  - A wait counter starts at entry.
  - mult_done seen while mult_start is low: capture result into a 144-bit register and go to SEND_RESULT with byte index = 0.
  - mult_done high during the mult_start cycle: ignored as stale.
  - Counter reaches MULT_TIMEOUT: set error, go to IDLE.
- SEND_RESULT sub-phases, held internally; current_state stays 5:
  - READY: when tx_busy == 0, assert tx_start for one cycle with tx_data = current byte, then go to WAIT_HI.
  - WAIT_HI: tx_busy == 1 goes to WAIT_LO. BUSY_TIMEOUT cycles without busy: set error, go to IDLE.
  - WAIT_LO: tx_busy == 0 increments the byte index and returns to READY. No timeout in this phase.
- Byte order: element 0..8, high byte first. Byte index b selects element b/2; high byte if b is even.
- After byte 17 completes WAIT_LO, go to IDLE.
- tx_data holds its value between tx_start pulses.
- rx_valid during COMPUTE/SEND_RESULT is ignored. No writes, no state change.
- Only one of wr_en_a, wr_en_b, mult_start, tx_start is high in any cycle.
- Result width is fixed at 16 bits. No arithmetic on result; it is transmitted verbatim.

Test Plan:
- Full transaction, A = 1..9 row-major, B = identity:
  - Stimulus: A5,03, A bytes, B bytes; mult_done 5 cycles after mult_start; tx_busy high 2 cycles after each tx_start, low 10 later.
  - Required: wr_en_a at addr 0..8 with data 1..9; one mult_start pulse; tx bytes 00,01,00,02,...,00,09; return to IDLE.
- Value check, A = B = all 2, result = nine 16'h000C: tx stream 00,0C repeated 9 times.
- Bad size: A5 then 04 -> error = 1, state 0, no write strobes. A following A5 clears error.
- Timeout: mult_done never asserted -> error after 255 cycles, state 0, no tx_start.
- Reset mid-stream: rst after 4th A byte -> all outputs 0, state 0. A fresh A5,03,... transaction writes A from addr 0.
- Back-pressure and stray bytes:
  - Stimulus: tx_busy held high 100 cycles before the first byte; rx_valid bytes injected during SEND_RESULT.
  - Required: tx_start waits for busy low; injected bytes cause no writes and the transmitted stream is unchanged.
